// File: rtl/dk_audio_pkg.sv
// Shared types and constants for the audio output mixer.
// Q1.7 gain format: 128 is unity, so the mix is rescaled by >>> 7.
package dk_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SAT,
        ST_PUSH
    } mix_state_e;

    localparam int Q17_UNITY = 128;
    localparam int Q_SHIFT   = $clog2(Q17_UNITY);
    localparam int SAT_MAX   = 32767;
    localparam int SAT_MIN   = -32768;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer; pointers carry an extra
// wrap bit so full and empty are distinguishable.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty  = (wr_q == rd_q);
    assign full_o = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop = pop_i && !empty;
    // A pop in the same cycle frees the slot, so a push into a full
    // buffer still lands when the head is leaving.
    assign do_push = push_i && (!full_o || do_pop);

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];

    // Pointer update; wrap is implicit in the AW+1 bit counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: data_o is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/dk_audio_out_mixer.sv
// Mixes NUM_CHANNELS signed samples with Q1.7 gains through one
// shared multiplier, saturates to 16 bits and buffers the result.
module dk_audio_out_mixer
    import dk_audio_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int GAIN_W       = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 audio_clk_en,
    input  logic [NUM_CHANNELS-1:0][15:0]        inputs,
    input  logic [NUM_CHANNELS-1:0][GAIN_W-1:0]  gains,
    output logic signed [15:0]                   out_sample,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 overflow,
    output logic                                 collision
);

    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PROD_W = 16 + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

    mix_state_e                          state_q;
    logic [NUM_CHANNELS-1:0][15:0]       in_snap_q;
    logic [NUM_CHANNELS-1:0][GAIN_W-1:0] gain_snap_q;
    logic signed [ACC_W-1:0]             acc_q;
    logic [CH_W-1:0]                     ch_q;
    logic [15:0]                         result_q;
    logic                                busy_q;
    logic                                overflow_q;
    logic                                collision_q;

    logic signed [15:0]       mul_a;
    logic signed [GAIN_W:0]   mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  shifted;
    logic [15:0]              sat_d;
    logic                     fifo_full;
    logic                     pop_w;
    logic                     push_w;

    // Shared multiplier: signed sample times zero-extended gain.
    assign mul_a = $signed(in_snap_q[ch_q]);
    assign mul_b = $signed({1'b0, gain_snap_q[ch_q]});
    assign prod  = mul_a * mul_b;

    // Rescale by unity (floor) and clamp to the 16-bit range.
    always_comb begin
        shifted = acc_q >>> Q_SHIFT;
        if (shifted > ACC_MAX)      sat_d = 16'(SAT_MAX);
        else if (shifted < ACC_MIN) sat_d = 16'(SAT_MIN);
        else                        sat_d = shifted[15:0];
    end

    assign pop_w  = out_valid && out_ready;
    assign push_w = (state_q == ST_PUSH);

    // Mix sequencer: snapshot, accumulate, saturate, push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_snap_q   <= '0;
            gain_snap_q <= '0;
            acc_q       <= '0;
            ch_q        <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            if (audio_clk_en && state_q != ST_IDLE) collision_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (audio_clk_en) begin
                        in_snap_q   <= inputs;
                        gain_snap_q <= gains;
                        acc_q       <= '0;
                        ch_q        <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    ch_q  <= ch_q + 1'b1;
                    if (ch_q == LAST_CH) state_q <= ST_SAT;
                end
                ST_SAT: begin
                    result_q <= sat_d;
                    state_q  <= ST_PUSH;
                end
                ST_PUSH: begin
                    if (fifo_full && !pop_w) overflow_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_w),
        .data_i  (result_q),
        .pop_i   (out_ready),
        .data_o  (out_sample),
        .valid_o (out_valid),
        .full_o  (fifo_full)
    );

    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_dk_audio_out_mixer.sv
// Randomised and directed bench for dk_audio_out_mixer with a
// queue-based reference model and a handshake-driven scoreboard.
module tb_dk_audio_out_mixer;

    localparam int N = 4;
    localparam int G = 8;
    localparam int D = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    audio_clk_en = 1'b0;
    logic [N-1:0][15:0]      inputs = '0;
    logic [N-1:0][G-1:0]     gains = '0;
    logic signed [15:0]      out_sample;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic                    busy;
    logic                    overflow;
    logic                    collision;

    int checks = 0;
    int errors = 0;
    int pops = 0;

    int     exp_q[$];
    int     cyc = 0;
    longint last_acc = -100;
    bit     pend = 0;
    int     pend_val = 0;
    longint due = 0;
    int     occ = 0;
    bit     ovf_exp = 0;
    bit     col_exp = 0;

    dk_audio_out_mixer #(
        .NUM_CHANNELS (N),
        .GAIN_W       (G),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .audio_clk_en (audio_clk_en),
        .inputs       (inputs),
        .gains        (gains),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .overflow     (overflow),
        .collision    (collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int mix(input logic [N-1:0][15:0] in,
                               input logic [N-1:0][G-1:0] g);
        longint s = 0;
        for (int i = 0; i < N; i++)
            s += longint'($signed(in[i])) * longint'(g[i]);
        s = s >>> 7;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    // Reference model: strobe acceptance, drop decision, expected queue.
    always @(negedge clk) begin
        int pop_m;
        int push_m;
        cyc++;
        if (reset) begin
            pend = 0;
            occ = 0;
            exp_q.delete();
            ovf_exp = 0;
            col_exp = 0;
            last_acc = -100;
        end else begin
            pop_m = (occ > 0 && out_ready) ? 1 : 0;
            push_m = 0;
            if (pend && due == cyc) begin
                pend = 0;
                if (occ < D || pop_m == 1) begin
                    exp_q.push_back(pend_val);
                    push_m = 1;
                end else begin
                    ovf_exp = 1;
                end
            end
            occ = occ + push_m - pop_m;
            if (audio_clk_en) begin
                if (cyc - last_acc >= N + 3) begin
                    last_acc = cyc;
                    pend = 1;
                    pend_val = mix(inputs, gains);
                    due = cyc + N + 2;
                end else begin
                    col_exp = 1;
                end
            end
        end
    end

    // Monitor: every accepted output must match the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", out_sample, 0);
            end else begin
                chk("sample", int'(out_sample), exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe();
        audio_clk_en = 1'b1;
        tick(1);
        audio_clk_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic set_all(input int v, input int g);
        for (int i = 0; i < N; i++) begin
            inputs[i] = 16'(v);
            gains[i] = 8'(g);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_sample"}, out_sample, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_col"}, collision, 0);
        tick(1);
    endtask

    task automatic one_mix(input string tag, input int v, input int g,
                           input int exp);
        int p0;
        set_all(v, g);
        p0 = pops;
        out_ready = 1'b1;
        strobe();
        tick(N + 6);
        chk({tag, "_pops"}, pops - p0, 1);
        chk({tag, "_model"}, mix(inputs, gains), exp);
    endtask

    initial begin
        int lat;
        int p0;
        int got;
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p0;
        int got;

        tick(3);
        reset = 1'b0;
        check_idle_outputs("reset");

        // Basic mix and latency.
        inputs[0] = 16'(1000);
        inputs[1] = 16'(2000);
        inputs[2] = 16'(-500);
        inputs[3] = 16'(0);
        for (int i = 0; i < N; i++) gains[i] = 8'd128;
        out_ready = 1'b1;
        audio_clk_en = 1'b1;
        lat = -1;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            audio_clk_en = 1'b0;
            @(negedge clk);
            if (k == 2) chk("busy_accum", busy, 1);
            if (lat < 0 && out_valid) begin
                lat = k;
                got = int'(out_sample);
            end
        end
        chk("latency", lat, N + 3);
        chk("basic_value", got, 2500);
        chk("busy_done", busy, 0);

        one_mix("sat_hi", 30000, 255, 32767);
        one_mix("sat_lo", -30000, 255, -32768);

        set_all(0, 128);
        inputs[0] = 16'(-3);
        gains[0] = 8'd64;
        p0 = pops;
        strobe();
        tick(N + 6);
        chk("floor_pops", pops - p0, 1);

        // Buffer fill and overflow.
        do_reset();
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            set_all(100 * (s + 1), 128);
            strobe();
            tick(9);
        end
        @(negedge clk);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_model", ovf_exp, 1);
        tick(1);
        p0 = pops;
        out_ready = 1'b1;
        tick(10);
        chk("ovf_drain", pops - p0, 4);
        chk("ovf_sticky", overflow, 1);

        // Collision.
        do_reset();
        set_all(7, 128);
        p0 = pops;
        strobe();
        tick(2);
        set_all(9, 128);
        strobe();
        tick(15);
        chk("col_flag", collision, 1);
        chk("col_pops", pops - p0, 1);

        // Reset during accumulation.
        do_reset();
        set_all(1234, 128);
        p0 = pops;
        strobe();
        tick(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check_idle_outputs("midrst");
        tick(15);
        chk("midrst_nopush", pops - p0, 0);
        one_mix("after_rst", 1234, 128, 4936);

        // Randomised traffic with inputs changing every cycle.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: inputs[i] = 16'h7fff;
                    1: inputs[i] = 16'h8000;
                    default: inputs[i] = 16'($urandom);
                endcase
                gains[i] = ($urandom_range(0, 3) == 0) ? 8'hff
                                                       : 8'($urandom);
            end
            audio_clk_en = ($urandom_range(0, 5) == 0);
            if (c < 2000) out_ready = ($urandom_range(0, 2) != 0);
            else          out_ready = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        audio_clk_en = 1'b0;
        out_ready = 1'b1;
        tick(30);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_valid", out_valid, 0);
        chk("rand_ovf", overflow, ovf_exp);
        chk("rand_col", collision, col_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dk_audio_out_mixer.md
DK_AUDIO_OUT_MIXER -- requirements
Module: dk_audio_out_mixer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of discrete sound channels mixed.
REQ-002 SHALL have parameter GAIN_W, default 8: unsigned per-channel gain width, Q1.7 format (128 = unity).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output sample buffer depth, power of two.
REQ-004 clk  input  1  single system clock; all logic on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 audio_clk_en  input  1  one-cycle sample strobe at SAMPLE_RATE.
REQ-007 inputs  input  NUM_CHANNELS x 16 signed  channel samples, e.g. walk, jump, stomp, boom stage outputs.
REQ-008 gains  input  NUM_CHANNELS x GAIN_W unsigned  per-channel gain.
REQ-009 out_sample  output  16 signed  FIFO head sample.
REQ-010 out_valid  output  1  out_sample holds a valid sample.
REQ-011 out_ready  input  1  consumer accepts the head sample when out_valid and out_ready are both high.
REQ-012 busy  output  1  high while the mix state machine is not IDLE.
REQ-013 overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-014 collision  output  1  sticky: audio_clk_en arrived while busy.

Function
REQ-015 SHALL implement a state machine with states IDLE, ACCUM, SAT and PUSH.
REQ-016 IDLE + audio_clk_en: snapshot all inputs and gains into registers, clear accumulator and channel index, go to ACCUM.
REQ-017 ACCUM: one channel per clock; acc += inputs[i] * gains[i] (signed x zero-extended unsigned), one shared multiplier; after channel NUM_CHANNELS-1, go to SAT.
REQ-018 Accumulator width SHALL be 16+GAIN_W+1+clog2(NUM_CHANNELS) bits; no internal overflow is possible.
REQ-019 SAT: arithmetic shift acc right by 7 (floor), clamp to [-32768, 32767], register result, go to PUSH.
REQ-020 PUSH: write result to FIFO if not full, else drop it and set overflow; go to IDLE in the same cycle.
REQ-021 Latency from the audio_clk_en cycle to out_valid rising (empty FIFO) SHALL be NUM_CHANNELS+3 clocks.
REQ-022 audio_clk_en while busy SHALL be ignored (no snapshot) and SHALL set collision.
REQ-023 FIFO: first-word-fall-through; a pop occurs on out_valid && out_ready; out_valid = not empty.
REQ-024 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; the dropped/overflow decision uses pre-pop fullness.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
REQ-026 inputs and gains changing during ACCUM SHALL not affect the sample in progress.

Reset
REQ-027 Reset SHALL force state IDLE, FIFO empty, out_valid=0, out_sample=0, busy=0, overflow=0, collision=0, and accumulator 0.
REQ-028 Reset asserted mid-mix SHALL abandon the partial sample; nothing is pushed after release.
REQ-029 Sticky flags SHALL clear only on reset.

Structure
REQ-030 Package dk_audio_pkg SHALL hold the state enum, the Q1.7 unity constant (128), and SAT_MAX/SAT_MIN.
REQ-031 The FIFO SHALL be a sub-module named sample_fifo, parameterised by width and depth.

Verification
REQ-032 Inputs 1000/2000/-500/0 with all gains 128, one strobe, out_ready=1 -> out_sample=2500, out_valid pulses 7 clocks after the strobe.
REQ-033 All inputs 30000 with gains 255 -> 32767; all inputs -30000 with gains 255 -> -32768.
REQ-034 out_ready=0 with 5 strobes spaced 10 clocks -> 4 samples buffered in order, fifth dropped, overflow=1; then out_ready=1 -> exactly 4 pops.
REQ-035 Second strobe 3 clocks after the first -> a single sample is produced and collision=1.
REQ-036 Reset asserted in ACCUM cycle 2 -> no sample appears, all outputs 0; the next strobe after release mixes normally.
REQ-037 Gain 64 on channel 0 with input -3 and others 0 -> out_sample=-2 (floor of -1.5).
